// File: rtl/tmc_spi_master.sv
// rtl/tmc_spi_master.sv - memory-mapped SPI master for 40-bit TMC driver datagrams
// Mode 3 (SCK idle high); firmware loads TX regs, starts, polls BUSY, reads RX regs.
module tmc_spi_master #(
   parameter int CLK_DIV    = 4,
   parameter int FRAME_BITS = 40
) (
   input  logic        clk_in,
   input  logic        reset_n_in,
   input  logic        enable,
   input  logic        mem_valid,
   input  logic [4:0]  addr_in,
   input  logic [3:0]  wstrb_in,
   input  logic [31:0] data_in,
   output logic        ready,
   output logic [31:0] r_data_out,
   input  logic        sdo_in,
   output logic        sck_out,
   output logic        sdi_out,
   output logic        cs_n_out
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_CS_SETUP = 3'd1;
   localparam logic [2:0] S_SCK_LO   = 3'd2;
   localparam logic [2:0] S_SCK_HI   = 3'd3;
   localparam logic [2:0] S_CS_HOLD  = 3'd4;
   localparam logic [2:0] S_GAP      = 3'd5;

   logic [2:0]            state;
   logic [7:0]            div_cnt;
   logic [5:0]            bit_cnt;
   logic [FRAME_BITS-1:0] shift;
   logic [7:0]            tx_addr;
   logic [31:0]           tx_data;
   logic [7:0]            rx_stat;
   logic [31:0]           rx_data;
   logic                  done;
   logic                  overrun;
   logic                  sdi_q;
   logic [31:0]           rd_mux;

   logic       busy;
   logic       req;
   logic       wr;
   logic       rd;
   logic [2:0] sel;
   logic       ctrl_wr;
   logic       start_req;
   logic       clr_ovr;
   logic       div_last;
   logic       last_bit;
   logic       unused_addr;

   assign busy        = (state != S_IDLE);
   assign req         = mem_valid & enable & ~ready;
   assign sel         = addr_in[4:2];
   assign wr          = ready & (wstrb_in != 4'h0);
   assign rd          = ready & (wstrb_in == 4'h0);
   assign ctrl_wr     = wr & (sel == 3'd2) & wstrb_in[0];
   assign start_req   = ctrl_wr & data_in[0];
   assign clr_ovr     = ctrl_wr & data_in[2];
   assign div_last    = (div_cnt == 8'(CLK_DIV - 1));
   assign last_bit    = (bit_cnt == 6'(FRAME_BITS - 1));
   assign unused_addr = ^addr_in[1:0];

   // Bus side: one-cycle ready, byte-laned register writes committed in the ready cycle
   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         ready   <= 1'b0;
         tx_addr <= 8'h00;
         tx_data <= 32'h0;
         overrun <= 1'b0;
      end else begin
         ready <= req;
         if (wr && sel == 3'd0 && wstrb_in[0]) tx_addr <= data_in[7:0];
         if (wr && sel == 3'd1) begin
            for (int b = 0; b < 4; b++) begin
               if (wstrb_in[b]) tx_data[8*b +: 8] <= data_in[8*b +: 8];
            end
         end
         if (clr_ovr)
            overrun <= 1'b0;
         else if (start_req && busy)
            overrun <= 1'b1;
      end
   end

   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         state   <= S_IDLE;
         div_cnt <= 8'd0;
         bit_cnt <= 6'd0;
         shift   <= '0;
         sdi_q   <= 1'b0;
         rx_stat <= 8'h00;
         rx_data <= 32'h0;
         done    <= 1'b0;
      end else if (state == S_IDLE) begin
         if (start_req) begin
            shift   <= {tx_addr, tx_data};
            done    <= 1'b0;
            bit_cnt <= 6'd0;
            div_cnt <= 8'd0;
            state   <= S_CS_SETUP;
         end
      end else if (!div_last) begin
         div_cnt <= div_cnt + 8'd1;
      end else begin
         div_cnt <= 8'd0;
         case (state)
            S_CS_SETUP: begin
               state <= S_SCK_LO;
               sdi_q <= shift[FRAME_BITS-1];
            end
            // Entering SCK_HI is the rising SCK edge: capture MISO into the LSB
            S_SCK_LO: begin
               state <= S_SCK_HI;
               shift <= {shift[FRAME_BITS-2:0], sdo_in};
            end
            S_SCK_HI: begin
               bit_cnt <= bit_cnt + 6'd1;
               if (last_bit) begin
                  state <= S_CS_HOLD;
               end else begin
                  state <= S_SCK_LO;
                  sdi_q <= shift[FRAME_BITS-1];
               end
            end
            S_CS_HOLD: state <= S_GAP;
            S_GAP: begin
               state   <= S_IDLE;
               rx_stat <= shift[FRAME_BITS-1 -: 8];
               rx_data <= shift[31:0];
               done    <= 1'b1;
               sdi_q   <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      rd_mux = 32'h0;
      case (sel)
         3'd0:    rd_mux = {24'h0, tx_addr};
         3'd1:    rd_mux = tx_data;
         3'd2:    rd_mux = {29'h0, overrun, done, busy};
         3'd3:    rd_mux = {24'h0, rx_stat};
         3'd4:    rd_mux = rx_data;
         default: rd_mux = 32'h0;
      endcase
   end

   // Zero outside the ready cycle so the top level can OR peripheral buses together
   assign r_data_out = rd ? rd_mux : 32'h0;
   assign cs_n_out   = ~((state == S_CS_SETUP) || (state == S_SCK_LO) ||
                         (state == S_SCK_HI)   || (state == S_CS_HOLD));
   assign sck_out    = (state != S_SCK_LO);
   assign sdi_out    = sdi_q;

endmodule

// File: doc/tmc_spi_master.md
Name: tmc_spi_master

Overview:
- Memory-mapped SPI master that carries 40-bit TMC stepper-driver datagrams (8-bit address/status + 32-bit data) between the picorv32 native memory bus and the driver's SDI/SDO/SCK/CS pins.
- Sits between the CPU address decoder (an enable in the IO window) and the gn[0..3] pads; the motor control path consumes it.
- Firmware writes address and data, then start; polls busy; reads back the returned status and data.

Parameters:
- CLK_DIV, 4, SCK half-period in clk_in cycles; legal range 1..255.
- FRAME_BITS, 40, bits per datagram; fixed at 40 and not expected to change.

Ports:
- clk_in  input  1  system clock (25 MHz)
- reset_n_in  input  1  asynchronous active-low reset
- enable  input  1  address-decode select from top level
- mem_valid  input  1  CPU request valid
- addr_in  input  5  byte address offset within block; bits [4:2] used
- wstrb_in  input  4  byte write strobes; 0 = read
- data_in  input  32  CPU write data
- ready  output  1  one-cycle access acknowledge
- r_data_out  output  32  read data; 0 whenever ready=0
- sdo_in  input  1  serial data from driver (MISO)
- sck_out  output  1  SPI clock, mode 3 (idle high)
- sdi_out  output  1  serial data to driver (MOSI)
- cs_n_out  output  1  chip select, active low

Behaviour:
- Register map (word offsets):
  - 0x00 TX_ADDR[7:0], R/W.
  - 0x04 TX_DATA[31:0], R/W.
  - 0x08 CTRL/STATUS: write bit0=1 starts a frame; write bit2=1 clears OVERRUN. Read bit0=BUSY, bit1=DONE (sticky), bit2=OVERRUN (sticky).
  - 0x0C RX_STAT[7:0], RO.
  - 0x10 RX_DATA[31:0], RO.
  - Other offsets read 0; writes to them are ignored.
- Reset values: ready=0, r_data_out=0, sck_out=1, sdi_out=0, cs_n_out=1. All registers and flags are 0.
- Bus handshake:
  - A request is mem_valid & enable & !ready.
  - ready rises the following cycle and is held high for exactly one cycle.
  - Read data is valid in the ready cycle and forced to 0 in all other cycles, so the top level can OR-combine peripheral read buses.
  - Writes commit in the ready cycle, per byte according to wstrb_in. Reading a DATA/DONE register does not clear it.
- Start handling:
  - A start write with BUSY=0 loads the 40-bit shift register {TX_ADDR, TX_DATA} and clears DONE.
  - BUSY rises the next cycle.
  - A start write with BUSY=1 is ignored and sets OVERRUN.
  - TX register writes while BUSY=1 are accepted and apply only to the next frame.
- State machine: IDLE -> CS_SETUP -> SCK_LO <-> SCK_HI -> CS_HOLD -> GAP -> IDLE. A divide counter counts CLK_DIV cycles per state.
  - CS_SETUP: cs_n_out=0, sck_out=1, for CLK_DIV cycles.
  - SCK_LO: sck_out=0; sdi_out is driven from the shift-register MSB on entry. Lasts CLK_DIV cycles.
  - SCK_HI: sck_out=1; sdo_in is sampled into the shift LSB on entry (the rising SCK edge). Lasts CLK_DIV cycles.
  - A 6-bit bit counter increments on each SCK_HI exit. After bit 39 the state moves to CS_HOLD instead of SCK_LO.
  - CS_HOLD: cs_n_out=0, sck_out=1, for CLK_DIV cycles.
  - GAP: cs_n_out=1 for CLK_DIV cycles. On GAP exit: RX_STAT=shift[39:32], RX_DATA=shift[31:0], DONE=1, BUSY=0, sdi_out=0.
- Timing: BUSY stays high for exactly CLK_DIV*(2*40+3) cycles. At CLK_DIV=4 this is 332 cycles.
- Data ordering: MSB first; address bit 7 is the first bit on sdi_out. The first bit received lands in RX_STAT[7].
- Reset mid-frame: outputs return to their reset values immediately (asynchronously). No RX update occurs and BUSY=0 after release.
- Simultaneous events:
  - A CPU read of STATUS in the GAP-exit cycle returns the pre-update values.
  - An OVERRUN set and clear in the same cycle: clear wins.

Test Plan:
- Reset: hold reset_n_in=0, toggle sdo_in -> cs_n_out=1, sck_out=1, sdi_out=0, all reads return 0 after release.
- Write TX_ADDR=0x6C, TX_DATA=0x000101D5, start; loopback sdi_out->sdo_in; CLK_DIV=4 -> 40 SCK falling edges; cs_n_out low for 328 cycles; BUSY high for 332 cycles; RX_STAT=0x6C, RX_DATA=0x000101D5, DONE=1.
- Driver model returns status 0x0F and data 0xDEADBEEF -> RX_STAT=0x0F, RX_DATA=0xDEADBEEF; sdi_out transitions occur only while sck_out=0, and sampling happens on SCK rising edges.
- Start again 10 cycles into a frame -> OVERRUN=1; frame completes unchanged. Write CTRL bit2=1 -> OVERRUN=0.
- Byte write TX_DATA with wstrb_in=0b0010, data 0x0000AB00 over 0x11223344 -> read TX_DATA returns 0x1122AB44; ready pulses one cycle and r_data_out=0 outside ready.
- Assert reset at bit 20 of a frame -> cs_n_out=1 within the same cycle; BUSY=0, DONE=0 and RX registers=0 after release.
